// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary to packed-BCD converter (shift-and-add-3 / double dabble)
// feeding the 8-digit seven-segment display driver. Values that do not fit in
// DIGITS decimal digits saturate to all nines and raise ovf_o.
//
// Ports:
//   clk_i    - system clock, rising edge
//   reset_i  - asynchronous active-low reset
//   start_i  - conversion request, only looked at while idle
//   bin_i    - unsigned binary operand, captured on the accepting edge
//   busy_o   - high while a conversion is in flight
//   done_o   - one-cycle pulse when bcd_o/ovf_o have just been updated
//   cs_o     - write strobe to the display driver, same timing as done_o
//   bcd_o    - packed BCD result, digit 0 (units) in bits [3:0]
//   ovf_o    - high when the last result saturated
module bin2bcd_seq #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cs_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
  function automatic logic [63:0] maxDecimal(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = maxDecimal(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [WORK_W-1:0]   r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sat;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_ovf;
  logic                r_done;

  logic                w_overRange;
  logic [WORK_W-1:0]   w_adjusted;
  logic [WORK_W-1:0]   w_shifted;

  assign w_overRange = ({{(64-BIN_W){1'b0}}, bin_i} > MAX_VAL);

  // Add-3 correction: every BCD nibble that is 5 or more gets +3 before the
  // shift so that it carries correctly into the next decimal digit. The
  // binary part below the BCD field passes through untouched.
  always_comb begin
    w_adjusted = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[BIN_W + 4*d +: 4] >= 4'd5) begin
        w_adjusted[BIN_W + 4*d +: 4] = r_work[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_shifted = {w_adjusted[WORK_W-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. An out-of-range operand skips the shift phase entirely
  // and goes straight to DONE, giving a one-clock saturation path.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_nextState = w_overRange ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, the BIN_W shift steps and the result latch.
  // done is registered from the DONE state so it lands in the same cycle as
  // the new bcd/ovf values and the FSM is already back in IDLE, which lets a
  // start in the done cycle be accepted without a dead cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_sat <= w_overRange;
            r_cnt <= '0;
            if (!w_overRange) begin
              r_work <= {{BCD_W{1'b0}}, bin_i};
            end
          end
        end
        SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_bcd <= r_sat ? ALL_NINES : r_work[WORK_W-1 -: BCD_W];
          r_ovf <= r_sat;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign busy_o = (r_state != IDLE);
  assign done_o = r_done;
  assign cs_o   = r_done;
  assign bcd_o  = r_bcd;
  assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
// Directed table-driven bench for bin2bcd_seq plus hand-written sequences for
// the multi-cycle corner cases (ignored start while busy, back-to-back
// conversions, asynchronous reset mid-conversion).
module tb_bin2bcd_seq;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int MAX_WAIT = 100;

  logic                clk;
  logic                resetN;
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                busy;
  logic                done;
  logic                cs;
  logic [4*DIGITS-1:0] bcd;
  logic                ovf;

  int nTests;
  int nFail;

  typedef struct {
    logic [BIN_W-1:0]    binVal;
    logic [4*DIGITS-1:0] expBcd;
    logic                expOvf;
    int                  expLat;
  } vector_t;

  vector_t vecs[9];

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .DIGITS(DIGITS)
  ) dut (
    .clk_i  (clk),
    .reset_i(resetN),
    .start_i(start),
    .bin_i  (bin),
    .busy_o (busy),
    .done_o (done),
    .cs_o   (cs),
    .bcd_o  (bcd),
    .ovf_o  (ovf)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Launch one conversion and wait for done. Returns the number of rising
  // edges from the accepting edge to the first sample where done is high.
  // Leaves start low and returns #1 after the edge that raised done.
  task automatic applyStimulus(input logic [BIN_W-1:0] value, output int lat,
                               output bit timedOut);
    @(negedge clk);
    start = 1'b1;
    bin   = value;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    lat      = 0;
    timedOut = 1'b1;
    if (done) begin
      timedOut = 1'b0;
    end
    while (timedOut && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) timedOut = 1'b0;
    end
    if (timedOut) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", lat);
    end
  endtask

  initial begin
    int      lat;
    bit      tmo;
    int      doneCount;
    int      gap;
    string   tag;

    nTests = 0;
    nFail  = 0;

    vecs[0] = '{27'd0,         32'h00000000, 1'b0, 28};
    vecs[1] = '{27'd12345678,  32'h12345678, 1'b0, 28};
    vecs[2] = '{27'd99999999,  32'h99999999, 1'b0, 28};
    vecs[3] = '{27'd100000000, 32'h99999999, 1'b1, 1};
    vecs[4] = '{27'd5,         32'h00000005, 1'b0, 28};
    vecs[5] = '{27'd10,        32'h00000010, 1'b0, 28};
    vecs[6] = '{27'd134217727, 32'h99999999, 1'b1, 1};
    vecs[7] = '{27'd1000,      32'h00001000, 1'b0, 28};
    vecs[8] = '{27'd9876543,   32'h09876543, 1'b0, 28};

    resetN = 1'b0;
    start  = 1'b0;
    bin    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_cs",   64'(cs),   64'd0);
    checkOutput("reset_bcd",  64'(bcd),  64'd0);
    checkOutput("reset_ovf",  64'(ovf),  64'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Table-driven conversions.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].binVal, lat, tmo);
      if (!tmo) begin
        tag = $sformatf("vec%0d", i);
        checkOutput({tag, "_lat"},  64'(lat),  64'(vecs[i].expLat));
        checkOutput({tag, "_bcd"},  64'(bcd),  64'(vecs[i].expBcd));
        checkOutput({tag, "_ovf"},  64'(ovf),  64'(vecs[i].expOvf));
        checkOutput({tag, "_cs"},   64'(cs),   64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_donewidth"}, 64'(done), 64'd0);
        checkOutput({tag, "_cswidth"},   64'(cs),   64'd0);
        checkOutput({tag, "_bcdhold"},   64'(bcd),  64'(vecs[i].expBcd));
      end
    end

    // A start pulse while busy must be ignored: one done, original operand.
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    doneCount = 0;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10) begin
        start = 1'b1;
        bin   = 27'd42;
      end
      @(posedge clk);
      #1;
      if (c == 10) start = 1'b0;
      if (done) begin
        doneCount++;
        if (doneCount == 1) begin
          lat = c;
          checkOutput("ignore_bcd", 64'(bcd), 64'h00000255);
        end
      end
    end
    checkOutput("ignore_donecount", 64'(doneCount), 64'd1);
    checkOutput("ignore_lat", 64'(lat), 64'd28);

    // Back-to-back: start held high, new operand presented in the done cycle.
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd9;
    @(posedge clk);
    #1;
    lat = 0;
    tmo = 1'b1;
    while (tmo && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) tmo = 1'b0;
    end
    checkOutput("b2b_first_timeout", 64'(tmo), 64'd0);
    checkOutput("b2b_first_lat", 64'(lat), 64'd28);
    checkOutput("b2b_first_bcd", 64'(bcd), 64'h00000009);
    bin = 27'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_second_busy", 64'(busy), 64'd1);
    gap = 1;
    tmo = 1'b1;
    while (tmo && gap < MAX_WAIT) begin
      @(posedge clk);
      #1;
      gap++;
      if (done) tmo = 1'b0;
    end
    checkOutput("b2b_second_timeout", 64'(tmo), 64'd0);
    checkOutput("b2b_gap", 64'(gap), 64'd29);
    checkOutput("b2b_second_bcd", 64'(bcd), 64'h00000010);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd87654321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("areset_busy", 64'(busy), 64'd0);
    checkOutput("areset_done", 64'(done), 64'd0);
    checkOutput("areset_cs",   64'(cs),   64'd0);
    checkOutput("areset_bcd",  64'(bcd),  64'd0);
    checkOutput("areset_ovf",  64'(ovf),  64'd0);
    doneCount = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done || cs) doneCount++;
      if (c == 2) begin
        @(negedge clk);
        resetN = 1'b1;
      end
    end
    checkOutput("areset_nopulse", 64'(doneCount), 64'd0);
    checkOutput("areset_bcd_after", 64'(bcd), 64'd0);
    applyStimulus(27'd87654321, lat, tmo);
    if (!tmo) begin
      checkOutput("post_reset_lat", 64'(lat), 64'd28);
      checkOutput("post_reset_bcd", 64'(bcd), 64'h87654321);
      checkOutput("post_reset_ovf", 64'(ovf), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-packed-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It sits directly upstream of the 8-digit seven-segment display driver. The block converts an unsigned binary value into 8 packed BCD digits. It presents the result on bcd_o with a one-cycle cs_o strobe, which the display driver latches as its 32-bit data word. Values that cannot be shown in 8 decimal digits saturate and raise an overflow flag.

Parameters:
BIN_W, 27, width of the binary input. 2^27-1 exceeds 99,999,999, so overflow is reachable.
DIGITS, 8, number of BCD digits. Output width is 4*DIGITS.

Ports:
clk_i  input  1  system clock, rising-edge.
reset_i  input  1  asynchronous, active-low reset (0 = reset).
start_i  input  1  conversion request, sampled only in IDLE.
bin_i  input  BIN_W  unsigned binary operand, captured on the accepting edge.
busy_o  output  1  high while a conversion is in progress.
done_o  output  1  one-cycle pulse when bcd_o/ovf_o are updated.
cs_o  output  1  one-cycle write strobe to the display driver, identical timing to done_o.
bcd_o  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
ovf_o  output  1  high when the last result saturated.

Behaviour:
- Reset (reset_i=0, asynchronous): state=IDLE, busy_o=0, done_o=0, cs_o=0, bcd_o=0, ovf_o=0, internal shift register and counter cleared. Reset asserted mid-conversion aborts it: no done_o/cs_o pulse, bcd_o returns to 0.
- States: IDLE, SHIFT, DONE.
- IDLE, start_i=1 at edge E0:
  - Capture bin_i.
  - If bin_i > 10^DIGITS-1: load saturation flag, go to DONE.
  - Else: load the working register {DIGITS*4 zeros, bin_i} (4*DIGITS+BIN_W bits), cnt=0, go to SHIFT.
  - busy_o=1 from E0.
- IDLE, start_i=0: hold.
- SHIFT, each edge:
  - Every BCD nibble >= 5 gets +3 (combinational, all nibbles in parallel).
  - The whole register shifts left 1, then cnt++.
  - On the edge where cnt==BIN_W-1 (the BIN_W-th shift), go to DONE.
  - Shifts occur at E1..E(BIN_W).
- DONE, one edge:
  - bcd_o <= upper 4*DIGITS bits of the working register, or all-9s (0x99999999) if saturated.
  - ovf_o <= saturation flag. done_o<=1, cs_o<=1, busy_o<=0, state=IDLE.
- Latency, normal path: done_o/cs_o high in the cycle after edge E(BIN_W+1), i.e. 28 clocks after the accepting edge with defaults.
- Latency, saturation path: done_o high after E1, i.e. 1 clock after the accepting edge.
- done_o and cs_o are exactly one cycle wide. bcd_o and ovf_o hold their values until the next DONE or reset.
- start_i while busy_o=1 is ignored. It is not queued, and bin_i changes during busy have no effect.
- start_i=1 in the cycle done_o=1 is accepted, because state is already IDLE. This gives back-to-back conversions with no dead cycle.
- Boundaries: bin_i=0 yields 0x00000000. bin_i=99,999,999 yields 0x99999999 with ovf_o=0. bin_i=100,000,000 yields 0x99999999 with ovf_o=1.
- Counter width: ceil(log2(BIN_W)) bits. No arithmetic carries out of the working register.

Test Plan:
- Reset released, start_i pulsed with bin_i=0 -> busy_o 1 for 28 cycles; done_o=cs_o=1 for 1 cycle; bcd_o=0x00000000, ovf_o=0.
- bin_i=12,345,678 -> bcd_o=0x12345678 exactly 28 cycles after the accepting edge; ovf_o=0.
- bin_i=99,999,999 then bin_i=100,000,000 -> first result 0x99999999, ovf_o=0 (28-cycle latency); second result 0x99999999, ovf_o=1, done 1 cycle after the accepting edge.
- Start with bin_i=255; at cycle 10 pulse start_i with bin_i=42 -> second start ignored, single done pulse, bcd_o=0x00000255.
- Hold start_i=1 continuously with bin_i=9 then bin_i=10 at the done cycle -> back-to-back conversions, done pulses 29 cycles apart, bcd_o=0x00000009 then 0x00000010.
- Drive reset_i=0 at cycle 15 of a conversion of 87,654,321 -> all outputs 0 immediately (asynchronous), no done/cs pulse; after release, a fresh start of 87,654,321 yields 0x87654321.
